// File: rtl/ln_pkg.sv
// ln_pkg: shared states and fixed-point constants for the ln(x) sequencer.
package ln_pkg;
  typedef enum logic [2:0] {
    LN_ST_IDLE,
    LN_ST_NORM,
    LN_ST_LUT,
    LN_ST_SQR,
    LN_ST_SUM,
    LN_ST_OUT
  } ln_st_e;
  localparam int LN_IN_FRAC_W = 15;
  localparam int LN_OUT_FRAC_W = 11;
  localparam int LN_F_W = 11;
  localparam int LN_LUT_DEPTH = 32;
  localparam logic signed [15:0] LN_ZERO_VAL = 16'sh8000;
endpackage

// File: rtl/ln_lut_exp.sv
// ln_lut_exp: ROM of round(ln(2)*(addr-15)) in Q4.11, addr = leading-one position of a Q16.15 operand.
module ln_lut_exp (
  input  logic [4:0]  addr,
  output logic [15:0] data
);
  localparam logic signed [15:0] ROM [32] = '{
    -16'sd21293, -16'sd19874, -16'sd18454, -16'sd17035,
    -16'sd15615, -16'sd14196, -16'sd12776, -16'sd11357,
    -16'sd9937,  -16'sd8517,  -16'sd7098,  -16'sd5678,
    -16'sd4259,  -16'sd2839,  -16'sd1420,  16'sd0,
    16'sd1420,   16'sd2839,   16'sd4259,   16'sd5678,
    16'sd7098,   16'sd8517,   16'sd9937,   16'sd11357,
    16'sd12776,  16'sd14196,  16'sd15615,  16'sd17035,
    16'sd18454,  16'sd19874,  16'sd21293,  16'sd22713
  };
  assign data = ROM[addr];
endmodule

// File: rtl/ln_seq_ctrl.sv
// ln_seq_ctrl: multi-cycle ln(x) of an unsigned Q16.15 operand to signed Q4.11.
// Normalises one bit per cycle, then LUT + quadratic ln(1+f) correction.
module ln_seq_ctrl
  import ln_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OUT_W = 16,
  parameter int SAT_EN = 1,
  parameter logic signed [OUT_W-1:0] ZERO_VAL = LN_ZERO_VAL
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_ln,
  output logic              out_zero,
  output logic              busy
);
  ln_st_e             state_q, state_d;
  logic [DATA_W-1:0]  sh_q, sh_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [15:0]        lut_q, lut_d, lut_data;
  logic [10:0]        f_q, f_d;
  logic [21:0]        sq_q, sq_d;
  logic [OUT_W-1:0]   ln_q, ln_d;
  logic               zero_q, zero_d;
  logic [11:0]        corr, mant;
  logic [16:0]        res;
  logic [15:0]        sum_out;

  ln_lut_exp u_lut (.addr(cnt_q), .data(lut_data));

  // 0.3125*f^2 folded into two shifts; f - corr stays non-negative for f < 1
  assign corr = 12'(sq_q[21:13]) + 12'(sq_q[21:15]);
  assign mant = 12'(f_q) - corr;
  assign res = {lut_q[15], lut_q} + {5'd0, mant};
  assign sum_out = (SAT_EN != 0 && res[16] != res[15]) ? (res[16] ? 16'h8000 : 16'h7fff) : res[15:0];

  assign in_ready = state_q == LN_ST_IDLE;
  assign busy = state_q != LN_ST_IDLE;
  assign out_valid = state_q == LN_ST_OUT;
  assign out_ln = ln_q;
  assign out_zero = zero_q;

  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    lut_d = lut_q;
    f_d = f_q;
    sq_d = sq_q;
    ln_d = ln_q;
    zero_d = zero_q;
    case (state_q)
      LN_ST_IDLE: if (in_valid) begin
        sh_d = in_x;
        cnt_d = 5'd31;
        zero_d = in_x == '0;
        ln_d = in_x == '0 ? ZERO_VAL : ln_q;
        state_d = in_x == '0 ? LN_ST_OUT : LN_ST_NORM;
      end
      LN_ST_NORM: begin
        sh_d = sh_q[31] ? sh_q : sh_q << 1;
        cnt_d = sh_q[31] ? cnt_q : cnt_q - 5'd1;
        state_d = sh_q[31] ? LN_ST_LUT : LN_ST_NORM;
      end
      LN_ST_LUT: begin
        lut_d = lut_data;
        f_d = sh_q[30:20];
        state_d = LN_ST_SQR;
      end
      LN_ST_SQR: begin
        sq_d = 22'(f_q) * 22'(f_q);
        state_d = LN_ST_SUM;
      end
      LN_ST_SUM: begin
        ln_d = OUT_W'(sum_out);
        state_d = LN_ST_OUT;
      end
      LN_ST_OUT: state_d = out_ready ? LN_ST_IDLE : LN_ST_OUT;
      default: state_d = LN_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LN_ST_IDLE;
      sh_q <= '0;
      cnt_q <= '0;
      lut_q <= '0;
      f_q <= '0;
      sq_q <= '0;
      ln_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      lut_q <= lut_d;
      f_q <= f_d;
      sq_q <= sq_d;
      ln_q <= ln_d;
      zero_q <= zero_d;
    end
  end
endmodule

// File: tb/tb_ln_seq_ctrl.sv
// tb_ln_seq_ctrl: directed and randomized checks of ln_seq_ctrl against an arithmetic ln model.
module tb_ln_seq_ctrl;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_x = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [15:0] out_ln;
  logic        out_zero;
  logic        busy;
  int checks = 0;
  int passed = 0;

  ln_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_ln(out_ln), .out_zero(out_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else passed++;
  endtask

  // ln(x) = p*ln2 + ln(1+f) with x = 2^(p-15)*(1+f); quadratic ln(1+f) ~ f - 0.3125 f^2
  function automatic int model_ln(input logic [31:0] x, output int p);
    logic [31:0] n;
    int f, sq, corr, lut, res;
    real r;
    if (x == 0) begin
      p = -1;
      return -32768;
    end
    p = 31;
    while (!x[p]) p--;
    n = x << (31 - p);
    f = int'(n[30:20]);
    sq = f * f;
    corr = sq / 8192 + sq / 32768;
    r = real'(p - 15) * $ln(2.0) * 2048.0;
    lut = int'($floor(r + 0.5));
    res = lut + f - corr;
    if (res > 32767) res = 32767;
    if (res < -32768) res = -32768;
    return res;
  endfunction

  task automatic run_op(input logic [31:0] x, input string name, input int hold, input bit intrude);
    int p, n, exp_ln, lat;
    logic [15:0] held;
    exp_ln = model_ln(x, p);
    lat = (x == 0) ? 0 : 35 - p;
    @(negedge clk);
    if (in_ready !== 1'b1) begin checks++; $display("FAIL %s_ready_before: got %0d expected 1", name, in_ready); end
    in_valid = 1;
    in_x = x;
    @(posedge clk);
    #1;
    in_valid = 0;
    in_x = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin
      in_valid = intrude;
      in_x = $urandom | 32'h1;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 0;
    chk({name, "_latency"}, n, lat);
    chk({name, "_ln"}, longint'($signed(out_ln)), exp_ln);
    chk({name, "_zero"}, out_zero, x == 0);
    chk({name, "_busy"}, {in_ready, busy}, 2'b01);
    held = out_ln;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_ln !== held || in_ready !== 1'b0) begin
        checks++;
        $display("FAIL %s_hold: got valid=%0d ln=%0d ready=%0d expected 1 %0d 0", name, out_valid, out_ln, in_ready, held);
      end
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk({name, "_done"}, {out_valid, in_ready, busy}, 3'b010);
  endtask

  task automatic test_reset;
    chk("reset_outputs", {in_ready, out_valid, busy, out_zero}, 4'b1000);
    chk("reset_ln", out_ln, 0);
  endtask

  task automatic test_directed;
    run_op(32'h0000_8000, "one", 0, 0);
    run_op(32'h0000_C000, "one_half", 0, 0);
    run_op(32'hFFFF_FFFF, "max", 0, 0);
    run_op(32'h0000_0001, "min", 0, 0);
    run_op(32'h0001_0000, "two", 0, 0);
    run_op(32'h0000_0000, "zero", 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++)
      run_op($urandom >> $urandom_range(0, 31), "rand", $urandom_range(0, 2), 0);
  endtask

  task automatic test_backpressure;
    run_op(32'h0123_4567, "bp", 10, 0);
    run_op(32'h0000_0000, "bp_zero", 10, 0);
  endtask

  task automatic test_busy_ignore;
    run_op(32'h0000_0003, "intrude", 2, 1);
    @(posedge clk);
    #1;
    chk("intrude_no_capture", {out_valid, busy}, 2'b00);
  endtask

  task automatic test_reset_mid;
    in_valid = 1;
    in_x = 32'h0000_0002;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("midreset_outputs", {in_ready, out_valid, busy, out_zero}, 4'b1000);
    chk("midreset_ln", out_ln, 0);
    @(negedge clk);
    rst_n = 1;
    run_op(32'h0000_C000, "after_reset", 0, 0);
  endtask

  initial begin
    #12;
    test_reset;
    @(negedge clk);
    rst_n = 1;
    test_directed;
    test_random;
    test_backpressure;
    test_busy_ignore;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
